// File: rtl/data_mem_mc_pkg.sv
// Shared memory-subsystem definitions: word width, default latency and the
// request FSM encoding used by the data, instruction and cache responders.
package data_mem_mc_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_MEM_LATENCY = 4;
  localparam int LAT_CNT_W           = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memState_t;

endpackage

// File: rtl/data_mem_mc_if.sv
// Load/store request bus between CPU and the multi-cycle data memory.
interface data_mem_mc_if;
  import data_mem_mc_pkg::*;

  logic              en;
  logic              wr;
  logic [15:0]       addr;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              busy;

  modport master (
    output en, wr, addr, data_in,
    input  data_out, data_valid, busy
  );

  modport slave (
    input  en, wr, addr, data_in,
    output data_out, data_valid, busy
  );

endinterface

// File: rtl/data_mem_mc_mem_array_1rw.sv
// Synchronous single-port storage with write enable and a registered read port.
module mem_array_1rw #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_rdata;

  // Read register only updates on a read so it holds the last read word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_mc.sv
// Multi-cycle data-memory responder: latches one LW/SW request and completes it
// a fixed LATENCY cycles later, stalling the CPU via busy meanwhile.
module data_mem_mc
  import data_mem_mc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = DEFAULT_MEM_LATENCY
) (
  input  logic          clk,
  input  logic          rst_n,
  data_mem_mc_if.slave  bus
);

  memState_t              r_state;
  memState_t              w_stateNext;
  logic [LAT_CNT_W-1:0]   r_count;
  logic                   r_wr;
  logic [DEPTH_LOG2-1:0]  r_index;
  logic [WORD_W-1:0]      r_wdata;
  logic                   r_dataValid;
  logic                   r_haveData;
  logic                   w_accept;
  logic                   w_done;
  logic                   w_memWe;
  logic                   w_memRe;
  logic [WORD_W-1:0]      w_memQ;
  logic                   w_unusedAddr;

  assign w_unusedAddr = ^{bus.addr[15:DEPTH_LOG2+1], bus.addr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.en) begin
          w_accept    = 1'b1;
          w_stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_count == '0) begin
          w_done      = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // The array is touched only on the completion edge, so an aborted write never lands.
  assign w_memWe = w_done & r_wr;
  assign w_memRe = w_done & ~r_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_wr        <= 1'b0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_dataValid <= 1'b0;
      r_haveData  <= 1'b0;
    end else begin
      r_dataValid <= w_memRe;
      if (w_memRe) begin
        r_haveData <= 1'b1;
      end
      if (w_accept) begin
        r_wr    <= bus.wr;
        r_index <= bus.addr[DEPTH_LOG2:1];
        r_wdata <= bus.data_in;
        r_count <= LAT_CNT_W'(LATENCY - 1);
      end else if (r_state == ST_WAIT && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  mem_array_1rw #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_re    (w_memRe),
    .i_addr  (r_index),
    .i_wdata (r_wdata),
    .o_rdata (w_memQ)
  );

  // Array read register is not reset, so gate it until a read has completed.
  assign bus.busy       = (r_state == ST_WAIT);
  assign bus.data_valid = r_dataValid;
  assign bus.data_out   = r_haveData ? w_memQ : '0;

endmodule
